// File: rtl/waterfall_pkg.sv
// Shared constants, FSM state encoding and framebuffer address payload for the
// waterfall line writer.
// Ports: none (package).
package waterfall_pkg;

  localparam int unsigned FREQ_BINS  = 64;
  localparam int unsigned FREQ_W     = 16;
  localparam int unsigned ROWS       = 32;
  localparam int unsigned PIX_W      = 4;
  localparam int unsigned SHIFT      = 8;

  localparam int unsigned BIN_ADDR_W = $clog2(FREQ_BINS);
  localparam int unsigned ROW_W      = $clog2(ROWS);
  localparam int unsigned PIX_ADDR_W = ROW_W + BIN_ADDR_W;
  localparam int unsigned PIX_MAX    = (1 << PIX_W) - 1;

  // sdft read latency from bin_addr to bin_out
  localparam int unsigned RD_LAT     = 2;
  // sweep-cycle landmarks, counted from the first cycle sdft_read is high
  localparam int unsigned SWEEP_LAST = FREQ_BINS;
  localparam int unsigned CAP_FIRST  = RD_LAT + 1;
  localparam int unsigned CAP_LAST   = FREQ_BINS + RD_LAT;
  localparam int unsigned CNT_W      = $clog2(CAP_LAST + 1);

  typedef enum logic [2:0] {
    IDLE,
    ARM,
    SWEEP,
    DRAIN,
    ADVANCE
  } wf_state_e;

  // framebuffer address: row in the upper bits, bin in the lower bits
  typedef struct packed {
    logic [ROW_W-1:0]      row;
    logic [BIN_ADDR_W-1:0] bin;
  } pix_addr_t;

endpackage

// File: rtl/waterfall_line_writer_if.sv
// Read port of the SDFT stage as seen by the waterfall line writer.
// Signals:
//   sdft_ready    sdft idle and readable (driven by sdft)
//   sdft_read     holds sdft in read mode (driven by writer)
//   sdft_bin_addr bin being read (driven by writer)
//   sdft_bin_out  magnitude, valid RD_LAT cycles after its bin_addr (driven by sdft)
// Modports: master = line writer, slave = sdft.
interface waterfall_line_writer_if;

  logic                                   sdft_ready;
  logic                                   sdft_read;
  logic [waterfall_pkg::BIN_ADDR_W-1:0]   sdft_bin_addr;
  logic [waterfall_pkg::FREQ_W-1:0]       sdft_bin_out;

  modport master (
    input  sdft_ready,
    input  sdft_bin_out,
    output sdft_read,
    output sdft_bin_addr
  );

  modport slave (
    output sdft_ready,
    output sdft_bin_out,
    input  sdft_read,
    input  sdft_bin_addr
  );

endinterface

// File: rtl/waterfall_line_writer_bin_to_pixel.sv
// Combinational magnitude -> colour index mapper.
// Default: linear map, pix = min(mag >> SHIFT, PIX_MAX).
// WATERFALL_LOG_EN defined: log map, pix = 0 for mag 0, else
//   min(floor(log2(mag)) + 1, PIX_MAX); SHIFT is unused.
// Ports:
//   mag   in  FREQ_W  sdft magnitude
//   pix_c out PIX_W   colour index (combinational)
module bin_to_pixel
  import waterfall_pkg::*;
(
  input  logic [FREQ_W-1:0] mag,
  output logic [PIX_W-1:0]  pix_c
);

`ifdef WATERFALL_LOG_EN
  localparam int unsigned LVL_W = $clog2(FREQ_W + 1);

  // significant-bit count of mag equals floor(log2(mag)) + 1 for mag > 0
  logic [LVL_W-1:0] nbits;

  always_comb begin
    nbits = '0;
    for (int i = 0; i < int'(FREQ_W); i++) begin
      if (mag[i]) nbits = LVL_W'(i + 1);
    end
    pix_c = (nbits > LVL_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : PIX_W'(nbits);
  end
`else
  logic [FREQ_W-1:0] scaled;

  always_comb begin
    scaled = mag >> SHIFT;
    pix_c  = (scaled > FREQ_W'(PIX_MAX)) ? PIX_W'(PIX_MAX) : PIX_W'(scaled);
  end
`endif

endmodule

// File: rtl/waterfall_line_writer.sv
// Waterfall line writer: on a line request, sweeps every sdft bin over the sdft
// read port, maps each magnitude to a colour index and writes one row of the
// circular waterfall framebuffer, then publishes that row as top_row.
// Colour map selected by macro WATERFALL_LOG_EN (see bin_to_pixel).
// Ports:
//   clk, reset_n  clock, async active-low reset
//   line_req      1-cycle pulse requesting one line
//   busy          high from accepted request until row advance
//   sdft          sdft read port (master side)
//   pix_we        framebuffer write strobe
//   pix_addr      {wr_row, bin}
//   pix_data      colour index
//   top_row       last fully written row
//   overrun       sticky: request dropped because one was already pending
module waterfall_line_writer
  import waterfall_pkg::*;
(
  input  logic                   clk,
  input  logic                   reset_n,
  input  logic                   line_req,
  output logic                   busy,
  waterfall_line_writer_if.master sdft,
  output logic                   pix_we,
  output pix_addr_t              pix_addr,
  output logic [PIX_W-1:0]       pix_data,
  output logic [ROW_W-1:0]       top_row,
  output logic                   overrun
);

  wf_state_e             state;
  logic [CNT_W-1:0]      cnt;
  logic [ROW_W-1:0]      wr_row;
  logic                  pending;
  logic                  read_q;
  logic [BIN_ADDR_W-1:0] addr_q;
  logic [PIX_W-1:0]      pix_c;
  logic                  capture_c;
  logic                  in_flight_c;
  logic                  take_c;

  assign sdft.sdft_read     = read_q;
  assign sdft.sdft_bin_addr = addr_q;

  bin_to_pixel u_map (
    .mag   (sdft.sdft_bin_out),
    .pix_c (pix_c)
  );

  // requests arriving here queue into the single pending slot
  assign in_flight_c = (state == ARM) || (state == SWEEP) || (state == DRAIN);
  // bin_out is valid for bin cnt-CAP_FIRST on these sweep cycles
  assign capture_c   = ((state == SWEEP) || (state == DRAIN)) &&
                       (cnt >= CNT_W'(CAP_FIRST)) && (cnt <= CNT_W'(CAP_LAST));
  assign take_c      = line_req | pending;

  // FSM, counters, capture/write stage, row pointer, pending/overrun
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state    <= IDLE;
      cnt      <= '0;
      read_q   <= 1'b0;
      addr_q   <= '0;
      busy     <= 1'b0;
      pix_we   <= 1'b0;
      pix_addr <= '0;
      pix_data <= '0;
      top_row  <= ROW_W'(ROWS - 1);
      wr_row   <= '0;
      pending  <= 1'b0;
      overrun  <= 1'b0;
    end else begin
      if (capture_c) begin
        pix_we   <= 1'b1;
        pix_addr <= '{row: wr_row, bin: BIN_ADDR_W'(cnt - CNT_W'(CAP_FIRST))};
        pix_data <= pix_c;
      end else begin
        pix_we <= 1'b0;
      end

      if (in_flight_c && line_req) begin
        if (pending) overrun <= 1'b1;
        else         pending <= 1'b1;
      end

      case (state)
        IDLE: begin
          if (take_c) begin
            state   <= ARM;
            busy    <= 1'b1;
            pending <= pending & line_req;
          end
        end

        ARM: begin
          if (sdft.sdft_ready) begin
            state  <= SWEEP;
            read_q <= 1'b1;
            addr_q <= '0;
            cnt    <= '0;
          end
        end

        // address for cycle c+1 is c, which also gives addr 0 on cycles 0 and 1
        SWEEP: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(SWEEP_LAST)) begin
            state  <= DRAIN;
            read_q <= 1'b0;
            addr_q <= '0;
          end else begin
            addr_q <= BIN_ADDR_W'(cnt);
          end
        end

        DRAIN: begin
          cnt <= cnt + CNT_W'(1);
          if (cnt == CNT_W'(CAP_LAST)) state <= ADVANCE;
        end

        // a pending or same-cycle request re-arms without dropping busy
        ADVANCE: begin
          top_row <= wr_row;
          wr_row  <= (wr_row == ROW_W'(ROWS - 1)) ? '0 : wr_row + ROW_W'(1);
          if (take_c) begin
            state   <= ARM;
            pending <= pending & line_req;
          end else begin
            state <= IDLE;
            busy  <= 1'b0;
          end
        end

        default: begin
          state <= IDLE;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_waterfall_line_writer.sv
// Self-checking bench for waterfall_line_writer: 2-cycle-latency sdft model,
// queue-based line model, per-cycle compare process, directed literal checks.
module tb_waterfall_line_writer;
  import waterfall_pkg::*;

  logic             clk;
  logic             reset_n;
  logic             line_req;
  logic             busy;
  logic             pix_we;
  pix_addr_t        pix_addr;
  logic [PIX_W-1:0] pix_data;
  logic [ROW_W-1:0] top_row;
  logic             overrun;

  waterfall_line_writer_if sif ();

  waterfall_line_writer dut (
    .clk      (clk),
    .reset_n  (reset_n),
    .line_req (line_req),
    .busy     (busy),
    .sdft     (sif),
    .pix_we   (pix_we),
    .pix_addr (pix_addr),
    .pix_data (pix_data),
    .top_row  (top_row),
    .overrun  (overrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // sdft model: magnitude table with exact 2-cycle read latency
  logic [FREQ_W-1:0] mem [FREQ_BINS];
  logic [FREQ_W-1:0] d1, d2;
  always @(posedge clk) begin
    d1 <= mem[sif.sdft_bin_addr];
    d2 <= d1;
  end
  assign sif.sdft_bin_out = d2;

  logic fixed_ready, rnd_ready, rand_ready;
  assign sif.sdft_ready = rand_ready ? rnd_ready : fixed_ready;
  always @(posedge clk) rnd_ready <= ($urandom_range(0, 3) != 0);

  int n_cmp = 0;
  int n_fail = 0;
  int wr_count = 0;
  int obs_data [FREQ_BINS];

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    n_cmp++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  function automatic int exp_pix(input int m);
    int v;
`ifdef WATERFALL_LOG_EN
    v = (m == 0) ? 0 : $clog2(m + 1);
`else
    v = m / (1 << SHIFT);
`endif
    return (v > int'(PIX_MAX)) ? int'(PIX_MAX) : v;
  endfunction

  // line model: each accepted request owes one row of 64 ascending writes
  typedef struct {
    int row;
    int bin;
    int data;
  } exp_t;
  exp_t q[$];
  int   owed = 0;
  int   next_row = 0;
  int   exp_top = ROWS - 1;
  int   exp_over = 0;
  int   top_sched = 0;
  int   top_sched_row = 0;
  int   rd_run = 0;
  bit   prev_read = 1'b0;
  bit   prev_ready = 1'b0;

  // at most one line in service plus one pending; anything more is an overrun
  always @(posedge clk) begin
    if (reset_n && line_req) begin
      if (owed < 2) begin
        owed++;
        for (int k = 0; k < int'(FREQ_BINS); k++)
          q.push_back('{next_row, k, exp_pix(int'(mem[k]))});
        next_row = (next_row + 1) % int'(ROWS);
      end else begin
        exp_over = 1;
      end
    end
  end

  // compare process
  always @(negedge clk) begin
    exp_t e;
    int   exp_a;
    if (!reset_n) begin
      q.delete();
      owed = 0; next_row = 0; exp_top = ROWS - 1; exp_over = 0;
      top_sched = 0; rd_run = 0; prev_read = 1'b0; prev_ready = 1'b0;
    end else begin
      if (top_sched != 0) begin
        exp_top   = top_sched_row;
        top_sched = 0;
      end
      chk(int'(top_row) == exp_top, "top_row", int'(top_row), exp_top);
      chk(int'(overrun) == exp_over, "overrun", int'(overrun), exp_over);
      chk(busy == (owed != 0), "busy", int'(busy), int'(owed != 0));

      if (sif.sdft_read && !prev_read)
        chk(prev_ready, "read_entry_ready", int'(prev_ready), 1);
      if (sif.sdft_read) begin
        exp_a = (rd_run == 0) ? 0 : rd_run - 1;
        chk(int'(sif.sdft_bin_addr) == exp_a, "bin_addr", int'(sif.sdft_bin_addr), exp_a);
        rd_run++;
      end else begin
        if (prev_read) chk(rd_run == int'(FREQ_BINS) + 1, "read_len", rd_run, FREQ_BINS + 1);
        rd_run = 0;
      end

      if (pix_we) begin
        wr_count++;
        obs_data[pix_addr.bin] = int'(pix_data);
        if (q.size() == 0) begin
          chk(1'b0, "pix_unexpected", int'(pix_addr.bin), -1);
        end else begin
          e = q.pop_front();
          chk(int'(pix_addr.row) == e.row && int'(pix_addr.bin) == e.bin, "pix_addr",
              int'(pix_addr), e.row * int'(FREQ_BINS) + e.bin);
          chk(int'(pix_data) == e.data, "pix_data", int'(pix_data), e.data);
          if (e.bin == int'(FREQ_BINS) - 1) begin
            top_sched     = 1;
            top_sched_row = e.row;
            owed--;
          end
        end
      end
      prev_read  = sif.sdft_read;
      prev_ready = sif.sdft_ready;
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic pulse_req();
    line_req = 1'b1;
    tick(1);
    line_req = 1'b0;
  endtask

  task automatic wait_read_rise();
    int n = 0;
    while (!sif.sdft_read && n < 500) begin tick(1); n++; end
    chk(sif.sdft_read, "read_start_timeout", int'(sif.sdft_read), 1);
  endtask

  task automatic wait_read_fall();
    int n = 0;
    while (sif.sdft_read && n < 200) begin tick(1); n++; end
    chk(!sif.sdft_read, "read_end_timeout", int'(sif.sdft_read), 0);
  endtask

  task automatic wait_done();
    int n = 0;
    while ((q.size() != 0 || busy) && n < 3000) begin tick(1); n++; end
    chk(n < 3000, "done_timeout", n, 3000);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int n;
    int old_top;
    int wc0;
    int lv [5];
    int lin_exp [3];

    reset_n = 1'b0; line_req = 1'b0; fixed_ready = 1'b1; rand_ready = 1'b0;
    for (int k = 0; k < int'(FREQ_BINS); k++) mem[k] = FREQ_W'(k << SHIFT);
    tick(3);
    reset_n = 1'b1;
    tick(2);
    chk(int'(top_row) == 31, "reset_top_row", int'(top_row), 31);
    chk(!pix_we && !sif.sdft_read && !busy, "reset_outputs",
        int'({pix_we, sif.sdft_read, busy}), 0);

    // single line, ready high
    old_top = int'(top_row);
    wc0 = wr_count;
    pulse_req();
    n = 0;
    while (int'(top_row) == old_top && n < 300) begin tick(1); n++; end
    chk(n == 69, "line_latency", n, 69);
    chk(int'(top_row) == 0, "t1_top_row", int'(top_row), 0);
    chk(wr_count - wc0 == 64, "t1_writes", wr_count - wc0, 64);
`ifdef WATERFALL_LOG_EN
    lin_exp = '{0, 11, 14};
`else
    lin_exp = '{0, 5, 15};
`endif
    chk(obs_data[0] == lin_exp[0], "t1_bin0", obs_data[0], lin_exp[0]);
    chk(obs_data[5] == lin_exp[1], "t1_bin5", obs_data[5], lin_exp[1]);
    chk(obs_data[63] == lin_exp[2], "t1_bin63", obs_data[63], lin_exp[2]);
    wait_done();

    // sdft not ready for 10 cycles after request
    fixed_ready = 1'b0;
    pulse_req();
    for (int i = 0; i < 10; i++) begin
      chk(!sif.sdft_read, "t2_read_while_not_ready", int'(sif.sdft_read), 0);
      tick(1);
    end
    fixed_ready = 1'b1;
    tick(1);
    chk(sif.sdft_read, "t2_sweep_start", int'(sif.sdft_read), 1);
    wait_done();

    // log-map points
    mem[0] = 16'd0; mem[1] = 16'd1; mem[2] = 16'd2; mem[3] = 16'd255; mem[4] = 16'd65535;
    pulse_req();
    wait_done();
`ifdef WATERFALL_LOG_EN
    lv = '{0, 1, 2, 8, 15};
`else
    lv = '{0, 0, 0, 0, 15};
`endif
    for (int i = 0; i < 5; i++) chk(obs_data[i] == lv[i], "t6_map", obs_data[i], lv[i]);

    // 33 back-to-back lines, random magnitudes and ready
    for (int k = 0; k < int'(FREQ_BINS); k++) mem[k] = FREQ_W'($urandom);
    rand_ready = 1'b1;
    wc0 = wr_count;
    pulse_req();
    for (int i = 0; i < 32; i++) begin
      wait_read_rise();
      tick($urandom_range(0, 55));
      pulse_req();
      wait_read_fall();
    end
    wait_done();
    chk(wr_count - wc0 == 33 * 64, "t3_writes", wr_count - wc0, 33 * 64);
    rand_ready = 1'b0;
    fixed_ready = 1'b1;
    tick(1);

    // three requests during one sweep
    wc0 = wr_count;
    pulse_req();
    wait_read_rise();
    tick(5);  pulse_req();
    tick(8);  pulse_req();
    tick(10); pulse_req();
    wait_done();
    chk(wr_count - wc0 == 128, "t4_writes", wr_count - wc0, 128);
    chk(overrun == 1'b1, "t4_overrun", int'(overrun), 1);

    // reset during a sweep
    pulse_req();
    wait_read_rise();
    tick(20);
    #1 reset_n = 1'b0;
    #1;
    chk(!sif.sdft_read, "t5_read_drop", int'(sif.sdft_read), 0);
    chk(!pix_we, "t5_we_drop", int'(pix_we), 0);
    tick(2);
    reset_n = 1'b1;
    tick(1);
    chk(int'(top_row) == 31, "t5_top_row", int'(top_row), 31);
    chk(!overrun, "t5_overrun_clear", int'(overrun), 0);
    pulse_req();
    wait_done();
    chk(int'(top_row) == 0, "t5_row0", int'(top_row), 0);

    tick(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
